// File: rtl/img_dram_reader_if.sv
// Memory read bus and pixel stream bundle for img_dram_reader.
// master = the reader, slave = memory plus downstream sink.
interface img_dram_reader_if #(
    parameter int A_WIDTH = 20,
    parameter int D_WIDTH = 8
) ();
    logic               ren;
    logic [A_WIDTH-1:0] raddr;
    logic [D_WIDTH-1:0] rdata;
    logic               pix_valid;
    logic [D_WIDTH-1:0] pix_data;
    logic               pix_last;
    logic               pix_ready;

    modport master (
        output ren, raddr, pix_valid, pix_data, pix_last,
        input  rdata, pix_ready
    );

    modport slave (
        input  ren, raddr, pix_valid, pix_data, pix_last,
        output rdata, pix_ready
    );
endinterface

// File: rtl/img_dram_reader.sv
// Reads a width x height pixel region from a one-cycle-latency memory in raster
// order and streams it out through a 2-entry FIFO with valid/ready handshake.
module img_dram_reader #(
    parameter int A_WIDTH   = 20,
    parameter int D_WIDTH   = 8,
    parameter int DIM_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [A_WIDTH-1:0]   base_addr,
    input  logic [DIM_WIDTH-1:0] width,
    input  logic [DIM_WIDTH-1:0] height,
    input  logic [DIM_WIDTH-1:0] stride,
    img_dram_reader_if.master    bus,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2} state_t;

    state_t                    state_q, state_d;
    logic [DIM_WIDTH-1:0]      w_q, w_d, h_q, h_d, stride_q, stride_d;
    logic [DIM_WIDTH-1:0]      x_q, x_d, y_q, y_d;
    logic [A_WIDTH-1:0]        row_q, row_d, addr_q, addr_d;
    logic                      rsp_q, rsp_d, rsp_last_q, rsp_last_d;
    logic [1:0][D_WIDTH-1:0]   mem_q, mem_d;
    logic [1:0]                lst_q, lst_d;
    logic                      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [1:0]                cnt_q, cnt_d;
    logic                      busy_q, busy_d, done_q, done_d;

    logic                      accept_s, push_s, pop_s, ren_s;
    logic                      row_end_s, final_s, head_last_s;
    logic [2:0]                credit_s;
    logic [A_WIDTH-1:0]        row_next_s;

    // Next-state logic: control FSM, address walker and output FIFO.
    always_comb begin
        accept_s    = start && !busy_q && (state_q == IDLE);
        push_s      = rsp_q;
        pop_s       = (cnt_q != 2'd0) && bus.pix_ready;
        // ren looks at this cycle's pop so a full-rate stream fits in only two entries
        credit_s    = 3'(cnt_q) + 3'(rsp_q) - 3'(pop_s);
        ren_s       = (state_q == ISSUE) && (credit_s < 3'd2);
        row_end_s   = (x_q == (w_q - DIM_WIDTH'(1)));
        final_s     = row_end_s && (y_q == (h_q - DIM_WIDTH'(1)));
        head_last_s = lst_q[rd_ptr_q];
        row_next_s  = row_q + A_WIDTH'(stride_q);

        state_d    = state_q;
        w_d        = w_q;
        h_d        = h_q;
        stride_d   = stride_q;
        x_d        = x_q;
        y_d        = y_q;
        row_d      = row_q;
        addr_d     = addr_q;
        rsp_d      = ren_s;
        rsp_last_d = ren_s && final_s;
        mem_d      = mem_q;
        lst_d      = lst_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q + 2'(push_s) - 2'(pop_s);
        busy_d     = busy_q && !done_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    w_d      = width;
                    h_d      = height;
                    stride_d = stride;
                    x_d      = DIM_WIDTH'(0);
                    y_d      = DIM_WIDTH'(0);
                    row_d    = base_addr;
                    addr_d   = base_addr;
                    busy_d   = 1'b1;
                    if ((width == DIM_WIDTH'(0)) || (height == DIM_WIDTH'(0))) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (ren_s) begin
                    if (row_end_s) begin
                        x_d    = DIM_WIDTH'(0);
                        y_d    = y_q + DIM_WIDTH'(1);
                        row_d  = row_next_s;
                        addr_d = row_next_s;
                    end else begin
                        x_d    = x_q + DIM_WIDTH'(1);
                        addr_d = addr_q + A_WIDTH'(1);
                    end
                    if (final_s) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = ISSUE;
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            DRAIN: begin
                if (pop_s && head_last_s) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (push_s) begin
            mem_d[wr_ptr_q] = bus.rdata;
            lst_d[wr_ptr_q] = rsp_last_q;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // State registers; reset also drops any response still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            w_q        <= DIM_WIDTH'(0);
            h_q        <= DIM_WIDTH'(0);
            stride_q   <= DIM_WIDTH'(0);
            x_q        <= DIM_WIDTH'(0);
            y_q        <= DIM_WIDTH'(0);
            row_q      <= A_WIDTH'(0);
            addr_q     <= A_WIDTH'(0);
            rsp_q      <= 1'b0;
            rsp_last_q <= 1'b0;
            mem_q      <= '{default: D_WIDTH'(0)};
            lst_q      <= 2'b00;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            h_q        <= h_d;
            stride_q   <= stride_d;
            x_q        <= x_d;
            y_q        <= y_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            rsp_q      <= rsp_d;
            rsp_last_q <= rsp_last_d;
            mem_q      <= mem_d;
            lst_q      <= lst_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.ren       = ren_s;
    assign bus.raddr     = addr_q;
    assign bus.pix_valid = (cnt_q != 2'd0);
    assign bus.pix_data  = mem_q[rd_ptr_q];
    assign bus.pix_last  = (cnt_q != 2'd0) && head_last_s;
    assign busy          = busy_q;
    assign done          = done_q;
endmodule
